octspi_host: RTL and testbench



---
 rtl/octspi_pkg.sv | 26 ++
 rtl/octspi_hdr_ser.sv | 23 ++
 rtl/octspi_host.sv | 191 +++++++++++++++++++
 tb/tb_octspi_host.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octspi_pkg.sv
// octspi_pkg: shared octal-SPI constants, host FSM states and the latched request layout.
// Used by both the host and the target side of the link.
package octspi_pkg;

    localparam logic [3:0] CMD_WRITE = 4'hA;
    localparam logic [3:0] CMD_READ  = 4'h2;
    localparam int         CMD_LEN   = 8;
    localparam int         DMY_LEN   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_GAP
    } host_state_e;

    typedef struct packed {
        logic        write;
        logic [3:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
    } host_req_t;

endpackage

// File: rtl/octspi_hdr_ser.sv
// octspi_hdr_ser: picks one byte of the 8-byte command header by index.
module octspi_hdr_ser
    import octspi_pkg::*;
(
    input  host_req_t  req,
    input  logic [2:0] idx,
    output logic [7:0] hdr_byte
);

    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            3'd0:    hdr_byte = {(req.write ? CMD_WRITE : CMD_READ), req.size};
            3'd3:    hdr_byte = req.len;
            3'd4:    hdr_byte = req.addr[31:24];
            3'd5:    hdr_byte = req.addr[23:16];
            3'd6:    hdr_byte = req.addr[15:8];
            3'd7:    hdr_byte = req.addr[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/octspi_host.sv
// octspi_host: octal-SPI initiator framing one read/write command per request on the byte bus.
// Define OCTSPI_HOST_ERR_EN to add the sticky write-underrun output `err`.
//   state | meaning
//   IDLE  | ready for a request, bus released
//   CMD   | eight header bytes driven
//   DUMMY | turnaround cycles, bus released, ncs still low
//   WDATA | payload driven from the write stream
//   RDATA | latency wait, then payload sampled from data_i
//   GAP   | ncs high for GAP_CYC cycles
module octspi_host
    import octspi_pkg::*;
#(
    parameter int RD_LAT  = 2,    // must be >= 1
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_size,
    input  logic [7:0]  req_len,
    input  logic [31:0] req_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        ncs,
    output logic [7:0]  data_o,
    output logic        data_t,
    input  logic [7:0]  data_i
`ifdef OCTSPI_HOST_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [7:0] CMD_LAST = 8'(CMD_LEN - 1);
    localparam logic [7:0] DMY_LAST = 8'(DMY_LEN - 1);
    localparam logic [7:0] LAT_LOAD = 8'(RD_LAT - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

    host_state_e state;
    host_req_t   req_q;
    host_req_t   req_sel;
    logic [7:0]  cnt;
    logic [7:0]  tmr;
    logic [7:0]  len_m1;
    logic [7:0]  hdr_byte;
    logic [7:0]  wr_byte;
    logic [2:0]  hdr_idx;

    // Header byte 0 must leave on the accept edge, before req_q is loaded.
    assign req_sel = (state == ST_IDLE) ? {req_write, req_size, req_len, req_addr} : req_q;
    assign hdr_idx = (state == ST_IDLE) ? 3'd0 : cnt[2:0] + 3'd1;
    assign len_m1  = req_q.len - 8'd1;
    assign wr_byte = wr_valid ? wr_data : 8'h00;

    octspi_hdr_ser u_hdr_ser (
        .req      (req_sel),
        .idx      (hdr_idx),
        .hdr_byte (hdr_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            cnt       <= '0;
            tmr       <= '0;
            ncs       <= 1'b1;
            data_t    <= 1'b1;
            data_o    <= 8'h00;
            req_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            done      <= 1'b0;
`ifdef OCTSPI_HOST_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q     <= req_sel;
                        cnt       <= '0;
                        ncs       <= 1'b0;
                        data_t    <= 1'b0;
                        data_o    <= hdr_byte;
                        req_ready <= 1'b0;
                        state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cnt == CMD_LAST) begin
                        cnt <= '0;
                        if (!req_q.write) begin
                            data_t <= 1'b1;
                            data_o <= 8'h00;
                            state  <= ST_DUMMY;
                        end else if (req_q.len == 8'd0) begin
                            ncs    <= 1'b1;
                            data_t <= 1'b1;
                            data_o <= 8'h00;
                            done   <= 1'b1;
                            tmr    <= GAP_LOAD;
                            state  <= ST_GAP;
                        end else begin
                            data_o   <= wr_byte;
                            wr_ready <= (req_q.len != 8'd1);
`ifdef OCTSPI_HOST_ERR_EN
                            if (!wr_valid) err <= 1'b1;
`endif
                            state    <= ST_WDATA;
                        end
                    end else begin
                        data_o <= hdr_byte;
                        cnt    <= cnt + 8'd1;
                        // wr_ready runs one cycle ahead of the byte it pops
                        if (cnt == CMD_LAST - 8'd1 && req_q.write && req_q.len != 8'd0)
                            wr_ready <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (cnt == len_m1) begin
                        ncs    <= 1'b1;
                        data_t <= 1'b1;
                        data_o <= 8'h00;
                        done   <= 1'b1;
                        tmr    <= GAP_LOAD;
                        state  <= ST_GAP;
                    end else begin
                        data_o   <= wr_byte;
                        cnt      <= cnt + 8'd1;
                        wr_ready <= (cnt + 8'd1 != len_m1);
`ifdef OCTSPI_HOST_ERR_EN
                        if (!wr_valid) err <= 1'b1;
`endif
                    end
                end
                ST_DUMMY: begin
                    if (cnt == DMY_LAST) begin
                        cnt <= '0;
                        if (req_q.len == 8'd0) begin
                            ncs   <= 1'b1;
                            done  <= 1'b1;
                            tmr   <= GAP_LOAD;
                            state <= ST_GAP;
                        end else begin
                            tmr   <= LAT_LOAD;
                            state <= ST_RDATA;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end else begin
                        rd_data  <= data_i;
                        rd_valid <= 1'b1;
                        if (cnt == len_m1) begin
                            ncs   <= 1'b1;
                            done  <= 1'b1;
                            tmr   <= GAP_LOAD;
                            state <= ST_GAP;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr == 8'd0) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_octspi_host.sv
// tb_octspi_host: directed and randomized transactions checked cycle by cycle against a timing model.
// Checks err as well when OCTSPI_HOST_ERR_EN is defined.
module tb_octspi_host;

    localparam int RD_LAT  = 2;
    localparam int GAP_CYC = 2;
    localparam int TRW     = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_size;
    logic [7:0]  req_len;
    logic [31:0] req_addr;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, done, ncs;
    logic [7:0]  data_o;
    logic        data_t;
    logic [7:0]  data_i;
`ifdef OCTSPI_HOST_ERR_EN
    logic        err;
`endif

    octspi_host #(.RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_len(req_len), .req_addr(req_addr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .ncs(ncs),
        .data_o(data_o), .data_t(data_t), .data_i(data_i)
`ifdef OCTSPI_HOST_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int cur      = 0;
    int wr_idx   = 0;
    bit exp_err  = 1'b0;
    int t_acc [4];

    logic        tx_w    [4];
    logic [3:0]  tx_size [4];
    logic [7:0]  tx_len  [4];
    logic [31:0] tx_addr [4];
    logic [7:0]  tx_wd   [4][256];
    logic        tx_hole [4][256];
    logic [7:0]  tx_rd   [4][256];

    logic [7:0]  tr_do   [4][TRW];
    logic [7:0]  tr_rd   [4][TRW];
    logic        tr_ncs  [4][TRW];
    logic        tr_dt   [4][TRW];
    logic        tr_done [4][TRW];
    logic        tr_wr   [4][TRW];
    logic        tr_rv   [4][TRW];
    logic        tr_rq   [4][TRW];

    task automatic check(input string tag, input int off, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, off, obs, exp);
        end
    endtask

    // One clock cycle: note an accept at the coming edge, record outputs, drive the target/source models.
    task automatic tick();
        int off;
        int k;
        if (req_valid && req_ready && !reset) begin
            cur = n_acc % 4;
            t_acc[cur] = cyc;
            n_acc++;
            wr_idx = 0;
        end
        @(negedge clk);
        cyc++;
        off = cyc - t_acc[cur];
        if (n_acc > 0 && off >= 0 && off < TRW) begin
            tr_do[cur][off] = data_o;   tr_rd[cur][off] = rd_data;
            tr_ncs[cur][off] = ncs;     tr_dt[cur][off] = data_t;
            tr_done[cur][off] = done;   tr_wr[cur][off] = wr_ready;
            tr_rv[cur][off] = rd_valid; tr_rq[cur][off] = req_ready;
        end
        k = off - 10 - RD_LAT;
        if (n_acc > 0 && !tx_w[cur] && k >= 0 && k < int'(tx_len[cur]))
            data_i = tx_rd[cur][k];
        else
            data_i = 8'($urandom);
        if (n_acc > 0 && tx_w[cur] && wr_idx < int'(tx_len[cur])) begin
            wr_valid = !tx_hole[cur][wr_idx];
            wr_data  = wr_valid ? tx_wd[cur][wr_idx] : 8'($urandom);
            if (wr_ready) wr_idx++;
        end else begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
        end
    endtask

    task automatic prep(input logic w, input logic [3:0] size, input logic [7:0] len,
                        input logic [31:0] addr, input int hole_pct);
        int b;
        b = n_acc % 4;
        tx_w[b] = w; tx_size[b] = size; tx_len[b] = len; tx_addr[b] = addr;
        for (int k = 0; k < 256; k++) begin
            tx_wd[b][k]   = 8'($urandom);
            tx_rd[b][k]   = 8'($urandom);
            tx_hole[b][k] = (int'($urandom_range(0, 99)) < hole_pct);
        end
        req_write = w; req_size = size; req_len = len; req_addr = addr;
        req_valid = 1'b1;
    endtask

    task automatic wait_acc(output bit ok, output int b);
        int n0;
        n0 = n_acc;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            if (n_acc != n0) ok = 1'b1;
        end
        b = cur;
        if (!ok) check("accept_timeout", cyc, 32'd0, 32'd1);
    endtask

    function automatic int end_off(input int b);
        if (tx_w[b]) return 9 + int'(tx_len[b]);
        if (tx_len[b] == 8'd0) return 11;
        return 10 + RD_LAT + int'(tx_len[b]);
    endfunction

    function automatic logic [7:0] hdr_exp(input int b, input int i);
        logic [63:0] h;
        h = {(tx_w[b] ? 4'hA : 4'h2), tx_size[b], 8'h00, 8'h00, tx_len[b], tx_addr[b]};
        return h[63 - 8*i -: 8];
    endfunction

    task automatic check_tx(input int b);
        int  e, len, k;
        bit  xdt, xwr, xrv;
        e   = end_off(b);
        len = int'(tx_len[b]);
        for (int off = 1; off < e + GAP_CYC; off++) begin
            xdt = (off <= 8) ? 1'b0 : !(tx_w[b] && off < e);
            xwr = tx_w[b] && off >= 8 && off <= 7 + len;
            xrv = !tx_w[b] && len > 0 && off >= 11 + RD_LAT && off <= 10 + RD_LAT + len;
            check("ncs", off, 32'(tr_ncs[b][off]), 32'(off >= e));
            check("data_t", off, 32'(tr_dt[b][off]), 32'(xdt));
            check("done", off, 32'(tr_done[b][off]), 32'(off == e));
            check("wr_ready", off, 32'(tr_wr[b][off]), 32'(xwr));
            check("rd_valid", off, 32'(tr_rv[b][off]), 32'(xrv));
            check("req_ready", off, 32'(tr_rq[b][off]), 32'd0);
            if (!xdt) begin
                if (off <= 8) begin
                    check("hdr_byte", off, 32'(tr_do[b][off]), 32'(hdr_exp(b, off - 1)));
                end else begin
                    k = off - 9;
                    check("wr_byte", off, 32'(tr_do[b][off]),
                          32'(tx_hole[b][k] ? 8'h00 : tx_wd[b][k]));
                end
            end
            if (xrv) check("rd_data", off, 32'(tr_rd[b][off]), 32'(tx_rd[b][off - 11 - RD_LAT]));
        end
        if (tx_w[b])
            for (int j = 0; j < len; j++) if (tx_hole[b][j]) exp_err = 1'b1;
`ifdef OCTSPI_HOST_ERR_EN
        check("err", e, 32'(err), 32'(exp_err));
`endif
    endtask

    task automatic finish_tx(input int b);
        req_valid = 1'b0;
        while (cyc - t_acc[b] < end_off(b) + GAP_CYC - 1) tick();
        check_tx(b);
    endtask

    task automatic run(input logic w, input logic [3:0] size, input logic [7:0] len,
                       input logic [31:0] addr, input int hole_pct);
        bit ok;
        int b;
        prep(w, size, len, addr, hole_pct);
        wait_acc(ok, b);
        if (ok) finish_tx(b);
        else req_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int b, ba, bb, ta;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_len = '0;
        req_addr = '0; wr_data = '0; wr_valid = 1'b0; data_i = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_ncs", 0, 32'(ncs), 32'd1);
        check("rst_data_t", 0, 32'(data_t), 32'd1);
        check("rst_data_o", 0, 32'(data_o), 32'd0);
        check("rst_req_ready", 0, 32'(req_ready), 32'd1);
        check("rst_wr_ready", 0, 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 0, 32'(rd_valid), 32'd0);
        check("rst_rd_data", 0, 32'(rd_data), 32'd0);
        check("rst_done", 0, 32'(done), 32'd0);
`ifdef OCTSPI_HOST_ERR_EN
        check("rst_err", 0, 32'(err), 32'd0);
`endif

        // write len 4: A0 00 00 04 00 00 00 10 11 22 33 44
        prep(1'b1, 4'h0, 8'd4, 32'h0000_0010, 0);
        b = n_acc % 4;
        tx_wd[b][0] = 8'h11; tx_wd[b][1] = 8'h22; tx_wd[b][2] = 8'h33; tx_wd[b][3] = 8'h44;
        wait_acc(ok, b);
        if (ok) finish_tx(b);

        // read len 3 returning AA BB CC
        prep(1'b0, 4'h0, 8'd3, 32'h0000_0020, 0);
        b = n_acc % 4;
        tx_rd[b][0] = 8'hAA; tx_rd[b][1] = 8'hBB; tx_rd[b][2] = 8'hCC;
        wait_acc(ok, b);
        if (ok) finish_tx(b);

        run(1'b1, 4'h3, 8'd0, 32'hDEAD_BEEF, 0);
        run(1'b0, 4'h5, 8'd0, 32'h1234_5678, 0);

        // write len 3 with byte 1 missing
        prep(1'b1, 4'h1, 8'd3, 32'h0000_0100, 0);
        tx_hole[n_acc % 4][1] = 1'b1;
        wait_acc(ok, b);
        if (ok) finish_tx(b);

        // reset in the middle of a read
        prep(1'b0, 4'h0, 8'd5, 32'h0000_0040, 0);
        wait_acc(ok, b);
        req_valid = 1'b0;
        while (ok && cyc - t_acc[b] < 5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_err = 1'b0;
        check("abort_ncs", 0, 32'(ncs), 32'd1);
        check("abort_data_t", 0, 32'(data_t), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            check("abort_done", i, 32'(done), 32'd0);
            check("abort_rd_valid", i, 32'(rd_valid), 32'd0);
            check("abort_ncs_hold", i, 32'(ncs), 32'd1);
            tick();
        end
        check("abort_req_ready", 0, 32'(req_ready), 32'd1);
`ifdef OCTSPI_HOST_ERR_EN
        check("abort_err", 0, 32'(err), 32'd0);
`endif
        run(1'b1, 4'h2, 8'd2, 32'h0000_0080, 0);

        // back-to-back with req_valid held high
        prep(1'b1, 4'h0, 8'd2, 32'h0000_0200, 0);
        wait_acc(ok, ba);
        ta = t_acc[ba];
        prep(1'b0, 4'h0, 8'd2, 32'h0000_0300, 0);
        wait_acc(ok, bb);
        if (ok) begin
            check("b2b_spacing", 0, 32'(t_acc[bb] - ta), 32'(end_off(ba) + GAP_CYC));
            check_tx(ba);
            finish_tx(bb);
        end else begin
            req_valid = 1'b0;
        end

        for (int i = 0; i < 14; i++) begin
            logic [7:0] len;
            len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 8));
            for (int j = int'($urandom_range(0, 3)); j > 0; j--) tick();
            run(1'($urandom_range(0, 1)), 4'($urandom), len, $urandom,
                ($urandom_range(0, 2) == 0) ? 20 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
